// File: rtl/ahb_stream_fifo_bridge.sv
// AHB-Lite slave that bridges a small register map onto a TX and an RX stream FIFO,
// with backpressure, two-cycle ERROR responses and an internal loopback path.
module ahb_stream_fifo_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [31:0]           HRDATA,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  input  logic                  testmodep
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_RSVD} reg_addr_t;
  typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} state_t;

  state_t          r_state, w_state_nx;
  reg_addr_t       w_addr, r_waddr;
  logic            r_wpend, r_ovf, r_live;
  logic [1:0]      r_ctrl;
  logic [31:0]     r_hrdata, w_rdata;

  logic [DATA_WIDTH-1:0] r_tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rx_mem [DEPTH];
  logic [AW-1:0]         r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [CNT_W-1:0]      r_tx_cnt, r_rx_cnt;
  logic [DATA_WIDTH-1:0] w_rx_wdata;

  logic w_acc, w_err, w_rd, w_wr_apply, w_loop_on, w_stream, w_loop_mv;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_full_eff;
  logic w_unused;

  assign w_unused   = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};
  assign w_addr     = reg_addr_t'(HADDR[3:2]);
  assign w_acc      = HSEL & HREADY & HTRANS[1];
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);

  // A DATA write still in its data phase counts towards TX occupancy.
  assign w_wr_apply    = r_wpend & HREADY;
  assign w_tx_push     = w_wr_apply & (r_waddr == REG_DATA);
  assign w_tx_full_eff = ((r_tx_cnt + CNT_W'(w_tx_push)) == FULL_CNT);

  assign w_err = (w_addr == REG_RSVD)
               | ((w_addr == REG_DATA) & ~HWRITE & w_rx_empty)
               | ((w_addr == REG_DATA) & HWRITE & w_tx_full_eff);
  assign w_rd     = w_acc & ~HWRITE & ~w_err;
  assign w_rx_pop = w_rd & (w_addr == REG_DATA);

  // r_live keeps the stream handshakes quiet while reset is asserted.
  assign w_loop_on  = r_live & r_ctrl[0] & (r_ctrl[1] | testmodep);
  assign w_stream   = r_live & r_ctrl[0] & ~(r_ctrl[1] | testmodep);
  assign dout       = r_tx_mem[r_tx_rd];
  assign dout_valid = w_stream & ~w_tx_empty;
  assign din_ready  = w_stream & (~w_rx_full | w_rx_pop);
  assign w_loop_mv  = w_loop_on & ~w_tx_empty & (~w_rx_full | w_rx_pop);
  assign w_tx_pop   = (dout_valid & dout_ready) | w_loop_mv;
  assign w_rx_push  = (din_valid & din_ready) | w_loop_mv;
  assign w_rx_wdata = w_loop_on ? dout : din;
  assign HRDATA     = r_hrdata;

  always_comb begin
    w_rdata = '0;
    unique case (w_addr)
      REG_DATA:   w_rdata = 32'(r_rx_mem[r_rx_rd]);
      REG_STATUS: w_rdata = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), 5'h00, r_ovf, w_tx_full, w_rx_empty};
      REG_CTRL:   w_rdata = {30'h0, r_ctrl};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_OKAY;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    HREADYOUT  = 1'b1;
    HRESP      = 2'b00;
    unique case (r_state)
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 2'b01;
        w_state_nx = S_ERR2;
      end
      S_ERR2: begin
        HRESP      = 2'b01;
        w_state_nx = (w_acc & w_err) ? S_ERR1 : S_OKAY;
      end
      default: w_state_nx = (w_acc & w_err) ? S_ERR1 : S_OKAY;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wpend  <= 1'b0;
      r_waddr  <= REG_DATA;
      r_hrdata <= '0;
      r_ctrl   <= 2'b01;
      r_ovf    <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (HREADY) begin
        r_wpend <= w_acc & HWRITE & ~w_err;
        r_waddr <= w_addr;
      end
      if (w_rd) r_hrdata <= w_rdata;
      if (w_wr_apply && r_waddr == REG_CTRL) r_ctrl <= HWDATA[1:0];
      // A fresh overflow wins over a simultaneous W1C clear.
      if (w_stream & din_valid & ~din_ready)                      r_ovf <= 1'b1;
      else if (w_wr_apply && r_waddr == REG_STATUS && HWDATA[2]) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wr] <= HWDATA[DATA_WIDTH-1:0];
        r_tx_wr           <= r_tx_wr + AW'(1);
      end
      if (w_tx_pop) r_tx_rd <= r_tx_rd + AW'(1);
      r_tx_cnt <= r_tx_cnt + CNT_W'(w_tx_push) - CNT_W'(w_tx_pop);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wr] <= w_rx_wdata;
        r_rx_wr           <= r_rx_wr + AW'(1);
      end
      if (w_rx_pop) r_rx_rd <= r_rx_rd + AW'(1);
      r_rx_cnt <= r_rx_cnt + CNT_W'(w_rx_push) - CNT_W'(w_rx_pop);
    end
  end
endmodule

// File: tb/tb_ahb_stream_fifo_bridge.sv
// Self-checking bench for ahb_stream_fifo_bridge: random data checked against
// queue-based TX/RX models plus expected OVF/CTRL state.
module tb_ahb_stream_fifo_bridge;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          HCLK = 1'b0;
  logic          HRESET, HSEL, HWRITE, HREADY, HREADYOUT;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS, HRESP;
  logic [DW-1:0] din, dout;
  logic          din_valid, din_ready, dout_valid, dout_ready, testmodep;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  logic          m_ovf;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_stream_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .testmodep(testmodep)
  );

  function automatic logic [31:0] exp_status();
    return {8'h00, 8'(m_tx.size()), 8'(m_rx.size()), 5'h00, m_ovf,
            (m_tx.size() == DEPTH), (m_rx.size() == 0)};
  endfunction

  function automatic logic [31:0] alias_addr(input logic [3:0] low);
    return ($urandom & 32'hFFFF_FFF0) | {28'h0, low};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  task automatic go_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic model_reset();
    m_tx.delete(); m_rx.delete(); m_ovf = 1'b0;
  endtask

  // Single non-pipelined transfer; reports OKAY and whether an error had the two-cycle shape.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic okay, output logic eshape);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick(1);
    go_idle(); HWDATA = data;
    okay = (HREADYOUT === 1'b1) && (HRESP === 2'b00);
    eshape = 1'b0;
    if (!okay) begin
      eshape = (HREADYOUT === 1'b0) && (HRESP === 2'b01);
      tick(1);
      eshape = eshape && (HREADYOUT === 1'b1) && (HRESP === 2'b01);
    end
    tick(1);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata,
                          output logic okay, output logic eshape);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick(1);
    go_idle();
    rdata = HRDATA;
    okay = (HREADYOUT === 1'b1) && (HRESP === 2'b00);
    eshape = 1'b0;
    if (!okay) begin
      eshape = (HREADYOUT === 1'b0) && (HRESP === 2'b01);
      tick(1);
      rdata = HRDATA;
      eshape = eshape && (HREADYOUT === 1'b1) && (HRESP === 2'b01);
    end
    tick(1);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ok, es;
    HRESET = 1'b1; go_idle(); HADDR = '0; HWDATA = '0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0; testmodep = 1'b0;
    model_reset();
    #3;
    checks++; if ({HREADYOUT, HRESP} !== 3'b100) begin errors++; $display("FAIL reset_resp: got %b want 100", {HREADYOUT, HRESP}); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
    checks++; if ({dout_valid, din_ready, dout} !== '0) begin errors++; $display("FAIL reset_stream: vld=%b rdy=%b dout=%h want 0", dout_valid, din_ready, dout); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    tick(2);
    bus_read(alias_addr(4'h4), rd, ok, es);
    checks++; if (!ok || rd !== 32'h1) begin errors++; $display("FAIL reset_status: ok=%b got %h want 00000001", ok, rd); end
    bus_read(alias_addr(4'h8), rd, ok, es);
    checks++; if (!ok || rd !== 32'h1) begin errors++; $display("FAIL reset_ctrl: ok=%b got %h want 00000001", ok, rd); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
  endtask

  task automatic test_tx_backpressure();
    logic [31:0] w[8];
    logic [31:0] rd;
    logic ok, es;
    dout_ready = 1'b0;
    foreach (w[i]) w[i] = $urandom;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0; end
      else go_idle();
      if (i > 0) begin
        HWDATA = w[i-1];
        m_tx.push_back(w[i-1][DW-1:0]);
        checks++; if ({HREADYOUT, HRESP} !== 3'b100) begin errors++; $display("FAIL b2b_write%0d: got %b want 100", i-1, {HREADYOUT, HRESP}); end
      end
      tick(1);
    end
    bus_read(32'h4, rd, ok, es);
    checks++; if (!ok || rd !== exp_status()) begin errors++; $display("FAIL tx_full_status: got %h want %h", rd, exp_status()); end
    bus_write(32'h0, $urandom, ok, es);
    checks++; if (ok || !es) begin errors++; $display("FAIL tx_overflow_err: ok=%b shape=%b want 0 1", ok, es); end
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL tx_after_err: got %h want %h", rd, exp_status()); end
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (dout_valid !== 1'b1 || dout !== m_tx[0]) begin errors++; $display("FAIL drain%0d: vld=%b dout=%h want 1 %h", i, dout_valid, dout, m_tx[0]); end
      void'(m_tx.pop_front());
      tick(1);
    end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: vld=%b want 0", dout_valid); end
    dout_ready = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [31:0] rd, last;
    logic ok, es, exp_rdy;
    for (int i = 0; i < 10; i++) begin
      din_valid = 1'b1; din = DW'($urandom);
      #1;
      exp_rdy = (m_rx.size() < DEPTH);
      checks++; if (din_ready !== exp_rdy) begin errors++; $display("FAIL din_ready%0d: got %b want %b", i, din_ready, exp_rdy); end
      if (exp_rdy) m_rx.push_back(din); else m_ovf = 1'b1;
      tick(1);
    end
    din_valid = 1'b0;
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL ovf_status: got %h want %h", rd, exp_status()); end
    bus_write(alias_addr(4'h4), $urandom & ~32'h4, ok, es);
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL ovf_w0_keeps: got %h want %h", rd, exp_status()); end
    bus_write(32'h4, 32'h4, ok, es);
    m_ovf = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL status_write_okay: got ERROR want OKAY"); end
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL ovf_w1c: got %h want %h", rd, exp_status()); end
    for (int i = 0; i < 8; i++) begin
      bus_read(32'h0, rd, ok, es);
      checks++; if (!ok || rd !== 32'(m_rx[0])) begin errors++; $display("FAIL rx_read%0d: ok=%b got %h want %h", i, ok, rd, 32'(m_rx[0])); end
      void'(m_rx.pop_front());
      last = rd;
    end
    bus_read(32'h0, rd, ok, es);
    checks++; if (ok || !es || rd !== last) begin errors++; $display("FAIL rx_empty_err: ok=%b shape=%b hrdata=%h want 0 1 %h", ok, es, rd, last); end
  endtask

  task automatic test_rx_full_pop();
    logic [31:0] rd, exp;
    logic ok, es;
    logic [DW-1:0] nw;
    for (int i = 0; i < DEPTH; i++) begin
      din_valid = 1'b1; din = DW'($urandom);
      m_rx.push_back(din);
      tick(1);
    end
    nw = DW'($urandom);
    HSEL = 1'b1; HTRANS = 2'b11; HWRITE = 1'b0; HADDR = 32'h0; din = nw;
    #1;
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL full_pop_din_ready: got %b want 1", din_ready); end
    @(posedge HCLK); #1;
    go_idle(); din_valid = 1'b0;
    exp = 32'(m_rx.pop_front());
    m_rx.push_back(nw);
    checks++; if (HRDATA !== exp || HRESP !== 2'b00) begin errors++; $display("FAIL full_pop_data: got %h resp=%b want %h 00", HRDATA, HRESP, exp); end
    tick(1);
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL full_pop_status: got %h want %h", rd, exp_status()); end
    while (m_rx.size() > 0) begin
      bus_read(32'h0, rd, ok, es);
      checks++; if (!ok || rd !== 32'(m_rx[0])) begin errors++; $display("FAIL full_pop_drain: ok=%b got %h want %h", ok, rd, 32'(m_rx[0])); end
      void'(m_rx.pop_front());
    end
  endtask

  task automatic test_loopback();
    logic [31:0] rd, wv;
    logic ok, es;
    int n;
    for (int mode = 0; mode < 2; mode++) begin
      bus_write(32'h8, (mode == 0) ? 32'h3 : 32'h1, ok, es);
      testmodep = (mode == 1);
      din_valid = 1'b1; din = DW'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        wv = $urandom;
        bus_write(32'h0, wv, ok, es);
        m_rx.push_back(wv[DW-1:0]);
        checks++; if (!ok || dout_valid !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL loop%0d_write%0d: ok=%b vld=%b rdy=%b want 1 0 0", mode, i, ok, dout_valid, din_ready); end
      end
      tick(2);
      din_valid = 1'b0;
      bus_read(32'h4, rd, ok, es);
      checks++; if (rd !== exp_status()) begin errors++; $display("FAIL loop%0d_status: got %h want %h", mode, rd, exp_status()); end
      while (m_rx.size() > 0) begin
        bus_read(32'h0, rd, ok, es);
        checks++; if (!ok || rd !== 32'(m_rx[0])) begin errors++; $display("FAIL loop%0d_read: ok=%b got %h want %h", mode, ok, rd, 32'(m_rx[0])); end
        void'(m_rx.pop_front());
      end
    end
    testmodep = 1'b0;
  endtask

  task automatic test_enable_off();
    logic [31:0] rd, wv;
    logic ok, es;
    bus_write(32'h8, 32'h0, ok, es);
    dout_ready = 1'b1;
    din_valid = 1'b1; din = DW'($urandom);
    wv = $urandom;
    bus_write(32'h0, wv, ok, es);
    m_tx.push_back(wv[DW-1:0]);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL en0_idle%0d: vld=%b rdy=%b want 0 0", i, dout_valid, din_ready); end
      tick(1);
    end
    din_valid = 1'b0;
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL en0_status: got %h want %h", rd, exp_status()); end
    bus_write(32'h8, 32'h1, ok, es);
    checks++; if (dout_valid !== 1'b1 || dout !== m_tx[0]) begin errors++; $display("FAIL en1_dout: vld=%b dout=%h want 1 %h", dout_valid, dout, m_tx[0]); end
    void'(m_tx.pop_front());
    tick(1);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL en1_drained: vld=%b want 0", dout_valid); end
    dout_ready = 1'b0;
  endtask

  task automatic test_reserved_and_reset();
    logic [31:0] rd, prev;
    logic ok, es;
    prev = HRDATA;
    bus_read(alias_addr(4'hC), rd, ok, es);
    checks++; if (ok || !es || rd !== prev) begin errors++; $display("FAIL rsvd_read: ok=%b shape=%b hrdata=%h want 0 1 %h", ok, es, rd, prev); end
    bus_write(32'hC, $urandom, ok, es);
    checks++; if (ok || !es) begin errors++; $display("FAIL rsvd_write: ok=%b shape=%b want 0 1", ok, es); end
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL rsvd_no_effect: got %h want %h", rd, exp_status()); end
    bus_write(32'h8, 32'h2, ok, es);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
    tick(1);
    go_idle(); HWDATA = $urandom;
    HRESET = 1'b1;
    #1;
    checks++; if ({HREADYOUT, HRESP} !== 3'b100 || HRDATA !== 32'h0) begin errors++; $display("FAIL async_reset_bus: rdy/resp=%b hrdata=%h want 100 0", {HREADYOUT, HRESP}, HRDATA); end
    checks++; if ({dout_valid, din_ready, dout} !== '0) begin errors++; $display("FAIL async_reset_stream: vld=%b rdy=%b dout=%h want 0", dout_valid, din_ready, dout); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    model_reset();
    tick(2);
    bus_read(32'h4, rd, ok, es);
    checks++; if (rd !== exp_status()) begin errors++; $display("FAIL reset_no_push: got %h want %h", rd, exp_status()); end
    bus_read(32'h8, rd, ok, es);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_ctrl_restored: got %h want 00000001", rd); end
  endtask

  initial begin
    test_reset();
    test_tx_backpressure();
    test_rx_overflow();
    test_rx_full_pop();
    test_loopback();
    test_enable_off();
    test_reserved_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
